// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite master that writes addr^SEED over a word window, reads it back and
// reports pass/fail, a saturating error count and the first failing address.
module ahb_lite_mem_tester #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          WORDS     = 256,
   parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] first_err_addr,
   output logic        HSEL,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_LAST, S_RD, S_RD_LAST, S_DONE} state_t;

   localparam logic [1:0]  TR_IDLE   = 2'b00;
   localparam logic [1:0]  TR_NONSEQ = 2'b10;
   localparam logic [15:0] LAST_IDX  = 16'(WORDS - 1);

   state_t      state_q, state_d;
   logic [31:0] haddr_q, haddr_d;
   logic [1:0]  htrans_q, htrans_d;
   logic        hwrite_q, hwrite_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic        hsel_q, hsel_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [15:0] err_q, err_d;
   logic [31:0] ferr_q, ferr_d;
   logic [15:0] idx_q, idx_d;
   // data-phase tracking: which transfer the slave is completing this cycle
   logic        dvld_q, dvld_d;
   logic [31:0] daddr_q, daddr_d;
   logic        dwr_q, dwr_d;
   logic        beat_done, beat_err;

   always_comb begin
      state_d  = state_q;
      haddr_d  = haddr_q;
      htrans_d = htrans_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      hsel_d   = hsel_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
      ferr_d   = ferr_q;
      idx_d    = idx_q;
      dvld_d   = dvld_q;
      daddr_d  = daddr_q;
      dwr_d    = dwr_q;

      beat_done = HREADY && dvld_q;
      beat_err  = beat_done && (HRESP || (!dwr_q && (HRDATA != (daddr_q ^ SEED))));
      if (beat_err) begin
         if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
         if (err_q == 16'd0)    ferr_d = daddr_q;
      end

      // the address phase accepted on this edge becomes the next data phase
      if (HREADY) begin
         dvld_d  = (htrans_q == TR_NONSEQ);
         daddr_d = haddr_q;
         dwr_d   = hwrite_q;
         if (htrans_q == TR_NONSEQ && hwrite_q) hwdata_d = haddr_q ^ SEED;
      end

      case (state_q)
         S_IDLE: if (start) begin
            state_d  = S_WR;
            htrans_d = TR_NONSEQ;
            haddr_d  = BASE_ADDR;
            hwrite_d = 1'b1;
            idx_d    = 16'd0;
            hsel_d   = 1'b1;
            busy_d   = 1'b1;
            err_d    = 16'd0;
            ferr_d   = 32'd0;
            pass_d   = 1'b0;
         end
         S_WR, S_RD: if (HREADY) begin
            if (idx_q == LAST_IDX) begin
               htrans_d = TR_IDLE;
               state_d  = (state_q == S_WR) ? S_WR_LAST : S_RD_LAST;
            end else begin
               haddr_d = haddr_q + 32'd4;
               idx_d   = idx_q + 16'd1;
            end
         end
         S_WR_LAST: if (HREADY) begin
            state_d  = S_RD;
            htrans_d = TR_NONSEQ;
            haddr_d  = BASE_ADDR;
            hwrite_d = 1'b0;
            idx_d    = 16'd0;
         end
         S_RD_LAST: if (HREADY) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hsel_d  = 1'b0;
            pass_d  = (err_d == 16'd0);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= S_IDLE;
         haddr_q  <= 32'd0;
         htrans_q <= TR_IDLE;
         hwrite_q <= 1'b0;
         hwdata_q <= 32'd0;
         hsel_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 16'd0;
         ferr_q   <= 32'd0;
         idx_q    <= 16'd0;
         dvld_q   <= 1'b0;
         daddr_q  <= 32'd0;
         dwr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
         hwdata_q <= hwdata_d;
         hsel_q   <= hsel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         ferr_q   <= ferr_d;
         idx_q    <= idx_d;
         dvld_q   <= dvld_d;
         daddr_q  <= daddr_d;
         dwr_q    <= dwr_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign HSEL           = hsel_q;
   assign HADDR          = haddr_q;
   assign HTRANS         = htrans_q;
   assign HWRITE         = hwrite_q;
   assign HWDATA         = hwdata_q;
   assign HBURST         = 3'b000;
   assign HSIZE          = 3'b010;

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Randomized bench: AHB slave model with configurable waits/errors/corrupt reads,
// per-transfer and per-run scoreboards checked by a negedge monitor.
module tb_ahb_lite_mem_tester;
   localparam logic [31:0] BASE = 32'h0;
   localparam int          W    = 4;
   localparam logic [31:0] SEED = 32'hA5A5_0000;
   localparam int          NX   = 2 * W;

   logic        HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0;
   logic        busy, done, pass, HSEL, HWRITE;
   logic [15:0] err_count;
   logic [31:0] first_err_addr, HADDR, HWDATA;
   logic [2:0]  HBURST, HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HRDATA = 32'd0;
   logic        HREADY = 1'b1, HRESP = 1'b0;

   ahb_lite_mem_tester #(.BASE_ADDR(BASE), .WORDS(W), .SEED(SEED)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
      .HSEL(HSEL), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP));

   always #5 HCLK = ~HCLK;

   typedef struct { logic [15:0] errs; logic [31:0] ferr; logic ok; int lat; } res_t;
   typedef struct { logic [31:0] addr; logic wr; } xfer_t;
   res_t  res_q[$];
   xfer_t xq[$];
   int    n_cmp = 0, n_bad = 0;

   int          cfg_wait[NX];
   bit          cfg_err[NX], cfg_ovr[NX];
   logic [31:0] cfg_val[NX];
   logic [31:0] mem_model[logic [31:0]];
   logic [31:0] smem[logic [31:0]];
   time         t_start;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // slave model + monitor: drives this cycle's response, then checks what the next edge will do
   bit          d_vld, d_wr, d_err, p_stall, accept;
   int          d_wait, d_idx, acc_n;
   logic [31:0] d_addr, p_haddr, p_hwdata;
   logic [1:0]  p_htrans;
   xfer_t       xe;
   res_t        re;

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         d_vld = 0; p_stall = 0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
         if (start) acc_n = 0;
         HREADY = !(d_vld && d_wait > 0);
         HRESP  = d_vld && d_err;
         HRDATA = 32'd0;
         if (d_vld && !d_wr)
            HRDATA = cfg_ovr[d_idx] ? cfg_val[d_idx] : (smem.exists(d_addr) ? smem[d_addr] : 32'd0);
         if (p_stall) begin
            chk("stall_haddr", HADDR, p_haddr);
            chk("stall_htrans", 32'(HTRANS), 32'(p_htrans));
            chk("stall_hwdata", HWDATA, p_hwdata);
         end
         if (d_vld && HREADY && d_wr) begin
            chk("hwdata", HWDATA, d_addr ^ SEED);
            if (!d_err) smem[d_addr] = HWDATA;
         end
         accept = HSEL && HTRANS == 2'b10 && HREADY;
         if (accept) begin
            if (xq.size() == 0) chk("unexpected_xfer", HADDR, 32'hFFFF_FFFF);
            else begin
               xe = xq.pop_front();
               chk("haddr", HADDR, xe.addr);
               chk("hwrite", 32'(HWRITE), 32'(xe.wr));
            end
         end
         if (done) begin
            if (res_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else begin
               re = res_q.pop_front();
               chk("err_count", 32'(err_count), 32'(re.errs));
               chk("first_err_addr", first_err_addr, re.ferr);
               chk("pass", 32'(pass), 32'(re.ok));
               chk("busy_at_done", 32'(busy), 32'd0);
               chk("latency", 32'(($time - t_start) / 10 - 1), 32'(re.lat));
            end
         end
         p_stall = !HREADY; p_haddr = HADDR; p_htrans = HTRANS; p_hwdata = HWDATA;
         if (HREADY) begin
            d_vld = accept;
            if (accept) begin
               d_addr = HADDR; d_wr = HWRITE; d_idx = (acc_n < NX) ? acc_n : 0;
               d_wait = cfg_wait[d_idx]; d_err = cfg_err[d_idx];
               acc_n++;
            end
         end else d_wait--;
      end
   end

   task automatic clear_cfg();
      for (int i = 0; i < NX; i++) begin
         cfg_wait[i] = 0; cfg_err[i] = 0; cfg_ovr[i] = 0; cfg_val[i] = 32'd0;
      end
   endtask

   task automatic rand_cfg();
      for (int i = 0; i < NX; i++) begin
         cfg_wait[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         cfg_err[i]  = ($urandom_range(0, 15) == 0);
         if (cfg_err[i] && cfg_wait[i] == 0) cfg_wait[i] = 1;
         cfg_ovr[i]  = !cfg_err[i] && i >= W && ($urandom_range(0, 9) == 0);
         cfg_val[i]  = $urandom;
      end
   endtask

   // reference: expected transfers and result derived from the window rules
   task automatic run(input bit abort_rd);
      res_t        r;
      xfer_t       x;
      logic [31:0] a, rv;
      bit          bad;
      int          k;
      r.errs = 16'd0; r.ferr = 32'd0; r.lat = 2 * W + 2;
      for (int i = 0; i < NX; i++) begin
         a = BASE + 32'(4 * (i % W));
         x.addr = a; x.wr = (i < W);
         xq.push_back(x);
         r.lat += cfg_wait[i];
         bad = cfg_err[i];
         if (i < W) begin
            if (!cfg_err[i]) mem_model[a] = a ^ SEED;
         end else if (!cfg_err[i]) begin
            rv  = cfg_ovr[i] ? cfg_val[i] : (mem_model.exists(a) ? mem_model[a] : 32'd0);
            bad = (rv != (a ^ SEED));
         end
         if (bad) begin
            if (r.errs == 16'd0) r.ferr = a;
            if (r.errs != 16'hFFFF) r.errs++;
         end
      end
      r.ok = (r.errs == 16'd0);
      if (!abort_rd) res_q.push_back(r);
      @(negedge HCLK); t_start = $time; #2 start = 1'b1;
      @(negedge HCLK); #2 start = 1'b0;
      if (abort_rd) begin
         k = 0;
         while (!(HSEL && HTRANS == 2'b10 && !HWRITE) && k < 200) begin @(negedge HCLK); k++; end
         if (k >= 200) chk("rd_phase_timeout", 32'(k), 32'd0);
         #2 HRESETn = 1'b0;
         #1;
         chk("rst_htrans", 32'(HTRANS), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_hsel", 32'(HSEL), 32'd0);
         xq.delete(); res_q.delete();
         @(negedge HCLK); #2 HRESETn = 1'b1;
      end else begin
         k = 0;
         while (res_q.size() != 0 && k < 1000) begin @(negedge HCLK); k++; end
         if (k >= 1000) begin chk("done_timeout", 32'(k), 32'd0); xq.delete(); res_q.delete(); end
         chk("xfers_left", 32'(xq.size()), 32'd0);
      end
      repeat (2) @(negedge HCLK);
   endtask

   initial begin
      clear_cfg();
      repeat (3) @(negedge HCLK);
      chk("rst_htrans0", 32'(HTRANS), 32'd0);
      chk("rst_haddr0", HADDR, 32'd0);
      chk("rst_hwrite0", 32'(HWRITE), 32'd0);
      chk("rst_hwdata0", HWDATA, 32'd0);
      chk("rst_busy0", 32'(busy), 32'd0);
      chk("rst_done0", 32'(done), 32'd0);
      chk("rst_pass0", 32'(pass), 32'd0);
      chk("rst_errs0", 32'(err_count), 32'd0);
      chk("rst_ferr0", first_err_addr, 32'd0);
      chk("hburst", 32'(HBURST), 32'd0);
      chk("hsize", 32'(HSIZE), 32'd2);
      #2 HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);

      run(0);                                     // clean zero-wait
      clear_cfg(); cfg_wait[1] = 3; run(0);       // stall on second write
      clear_cfg(); cfg_ovr[W + 2] = 1; cfg_val[W + 2] = 32'hDEAD_BEEF; run(0);
      clear_cfg(); cfg_err[1] = 1; cfg_wait[1] = 1; cfg_err[W + 3] = 1; cfg_wait[W + 3] = 1; run(0);
      clear_cfg(); run(1);                        // reset during read phase
      run(0);                                     // clean restart
      for (int n = 0; n < 20; n++) begin rand_cfg(); run(0); end
      clear_cfg(); run(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
